// File: rtl/timer_sched_pkg.sv
// Shared types and constants for the interval scheduler and its round-robin picker.
package timer_sched_pkg;

  localparam int CW_DEFAULT = 11;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    WAIT_BUSY = 3'd2,
    RUN       = 3'd3,
    DONE      = 3'd4
  } state_e;

endpackage

// File: rtl/timer_sched_rr_pick.sv
// Combinational round-robin picker: searches from last_i+1 upward (wrapping)
// and returns the first requesting index as one-hot and binary.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IW   = 2
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   last_i,
  output logic [NREQ-1:0] pick_o,
  output logic [IW-1:0]   idx_o,
  output logic            valid_o
);

  int unsigned j;

  // NOTE: every output gets a default before the search loop so no path
  // leaves a value unassigned, which would otherwise infer a latch.
  always_comb begin
    pick_o  = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    j       = 0;
    for (int k = 1; k <= NREQ; k++) begin
      j = (int'(last_i) + k) % NREQ;
      if (!valid_o && req_i[IW'(j)]) begin
        valid_o         = 1'b1;
        pick_o[IW'(j)]  = 1'b1;
        idx_o           = IW'(j);
      end
    end
  end

endmodule

// File: rtl/timer_sched.sv
// Grants one requester at a time to an external interval counter, waits for the
// counter to start and finish, then pulses done (or err if it never started).
module timer_sched
  import timer_sched_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int CW   = CW_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NREQ-1:0]  req_i,
  input  logic [NREQ*CW-1:0] req_cnt_i,
  output logic [NREQ-1:0]  gnt_o,
  output logic [NREQ-1:0]  done_o,
  output logic             err_o,
  output logic             tmr_en_o,
  output logic [CW-1:0]    tmr_cnt_o,
  input  logic             tmr_busy_i
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_e            state_q, state_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [NREQ-1:0]   done_q, done_d;
  logic              err_q, err_d;
  logic              tmr_en_q, tmr_en_d;
  logic [CW-1:0]     tmr_cnt_q, tmr_cnt_d;
  logic [IW-1:0]     last_gnt_q, last_gnt_d;
  logic [IW-1:0]     winner_q, winner_d;
  logic              wait_q, wait_d;

  logic [NREQ-1:0]   req_pick;
  logic [NREQ-1:0]   pick_oh;
  logic [IW-1:0]     pick_idx;
  logic              pick_valid;

  // The finishing requester still holds req during DONE; hide it so a
  // back-to-back grant from DONE only goes to a different requester.
  always_comb begin
    req_pick = req_i;
    if (state_q == DONE) req_pick[winner_q] = 1'b0;
  end

  rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
    .req_i   (req_pick),
    .last_i  (last_gnt_q),
    .pick_o  (pick_oh),
    .idx_o   (pick_idx),
    .valid_o (pick_valid)
  );

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    done_d     = '0;
    err_d      = 1'b0;
    tmr_en_d   = 1'b0;
    tmr_cnt_d  = tmr_cnt_q;
    last_gnt_d = last_gnt_q;
    winner_d   = winner_q;
    wait_d     = wait_q;

    unique case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (state_q == DONE) gnt_d = '0;
        if (pick_valid) begin
          state_d   = START;
          gnt_d     = pick_oh;
          winner_d  = pick_idx;
          tmr_en_d  = 1'b1;
          tmr_cnt_d = req_cnt_i[int'(pick_idx)*CW +: CW];
        end
      end
      START: begin
        state_d = WAIT_BUSY;
        wait_d  = 1'b0;
      end
      WAIT_BUSY: begin
        if (tmr_busy_i) begin
          state_d = RUN;
        end else if (wait_q) begin
          state_d    = DONE;
          err_d      = 1'b1;
          gnt_d      = '0;
          done_d     = '0;
          done_d[winner_q] = 1'b1;
          last_gnt_d = winner_q;
        end else begin
          wait_d = 1'b1;
        end
      end
      RUN: begin
        if (!tmr_busy_i) begin
          state_d    = DONE;
          gnt_d      = '0;
          done_d[winner_q] = 1'b1;
          last_gnt_d = winner_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its pre-edge value regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      done_q     <= '0;
      err_q      <= 1'b0;
      tmr_en_q   <= 1'b0;
      tmr_cnt_q  <= '0;
      last_gnt_q <= IW'(NREQ - 1);
      winner_q   <= '0;
      wait_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      done_q     <= done_d;
      err_q      <= err_d;
      tmr_en_q   <= tmr_en_d;
      tmr_cnt_q  <= tmr_cnt_d;
      last_gnt_q <= last_gnt_d;
      winner_q   <= winner_d;
      wait_q     <= wait_d;
    end
  end

  assign gnt_o     = gnt_q;
  assign done_o    = done_q;
  assign err_o     = err_q;
  assign tmr_en_o  = tmr_en_q;
  assign tmr_cnt_o = tmr_cnt_q;

endmodule

// File: doc/timer_sched.md
TIMER_SCHED -- requirements
Module: timer_sched

Interface
REQ-001 Parameter NREQ, default 4, number of requesters; legal range 2..8.
REQ-002 Parameter CW, default 11, count width; matches the shared interval counter's cnt port.
REQ-003 clk  input  1  sole clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 req  input  NREQ  per-requester interval request, level; held until that requester's done pulse.
REQ-006 req_cnt  input  NREQ*CW  per-requester interval value; slice i is bits [i*CW+CW-1 : i*CW].
REQ-007 gnt  output  NREQ  one-hot grant, registered.
REQ-008 done  output  NREQ  one-cycle completion pulse to the granted requester, registered.
REQ-009 err  output  1  one-cycle pulse when the counter fails to start.
REQ-010 tmr_en  output  1  start strobe to the shared counter (drives its cnt_en).
REQ-011 tmr_cnt  output  CW  interval value to the shared counter (drives its cnt).
REQ-012 tmr_busy  input  1  counter running flag (driven by the counter's ready).

Function
REQ-013 The FSM SHALL have states IDLE, START, WAIT_BUSY, RUN, DONE, encoded in a shared enum.
REQ-014 In IDLE with any req bit set, the block SHALL select the winner round-robin, starting at (last_gnt+1) mod NREQ, and go to START.
REQ-015 On that transition: gnt SHALL go one-hot to the winner; tmr_cnt SHALL latch the winner's req_cnt slice; tmr_en SHALL be 1 for exactly the START cycle.
REQ-016 tmr_cnt SHALL hold the latched value from START until the next grant; later req_cnt changes SHALL be ignored.
REQ-017 In WAIT_BUSY, tmr_busy=1 SHALL move the FSM to RUN.
REQ-018 If tmr_busy stays 0 for 2 consecutive WAIT_BUSY cycles, the FSM SHALL go to DONE with err pulsed in the DONE cycle.
REQ-019 In RUN, tmr_busy=0 SHALL move the FSM to DONE.
REQ-020 In DONE: done[winner]=1 for one cycle; gnt cleared to 0 in the same cycle; last_gnt updated to the winner; next state IDLE.
REQ-021 A requester dropping req after grant SHALL NOT abort the interval; done still pulses.
REQ-022 req_cnt=0 SHALL be legal; counter busy lasts 1 cycle and the sequence completes normally.
REQ-023 With the counter busy for N+1 cycles for value N, req at cycle 0 in IDLE SHALL give: gnt/tmr_en at cycle 1, RUN from cycle 3, done at cycle N+4.
REQ-024 Back-to-back: IDLE following DONE SHALL grant a pending request with no extra idle cycle.
REQ-025 At most one gnt bit and one done bit SHALL be high in any cycle; done is never high outside DONE.

Reset
REQ-026 Asserting rst SHALL immediately force: state IDLE, gnt=0, done=0, err=0, tmr_en=0, tmr_cnt=0, last_gnt=NREQ-1 (so requester 0 wins first).
REQ-027 Reset mid-interval SHALL drop gnt without a done pulse; the counter is reset by the same rst net.

Structure
REQ-028 A shared package SHALL hold the state enum and the default CW constant.
REQ-029 The round-robin selector SHALL be a separate sub-module rr_pick (inputs req and last_gnt, output one-hot pick plus index), purely combinational.
REQ-030 The block SHALL NOT contain the counter; it drives an external instance.

Verification (bench pairs the block with the real counter, with rst converted to that counter's active-low reset)
REQ-031 Single request: req=0001, req_cnt[0]=5 at cycle 0 -> gnt=0001 and tmr_en at cycle 1, tmr_cnt=5, done=0001 at cycle 9, gnt=0 at cycle 9.
REQ-032 Contention: req=1111 held with all values 2 -> grants in order 0,1,2,3,0; each done 6 cycles apart; never two gnt bits high.
REQ-033 Zero count: req=0100, req_cnt[2]=0 -> busy 1 cycle, done=0100 at cycle 4, err=0.
REQ-034 Stuck counter: tmr_busy forced 0, req=0010 -> err=1 and done=0010 in the same cycle, 4 cycles after req; then return to IDLE.
REQ-035 Reset mid-RUN: rst pulsed during a 100-count interval -> gnt=0 at once with no done; after release, a pending req=1000 is granted to requester 3.
REQ-036 Value change: req_cnt[1] changed from 7 to 20 after grant -> tmr_cnt stays 7, done after 7+4 cycles.
